// File: rtl/alu_result_monitor_if.sv
// ALU writeback capture bus and record-stream handshake for alu_result_monitor.
// The master side drives the ALU outputs and out_ready; the monitor is the slave.
interface alu_result_monitor_if #(
    parameter int unsigned SEQ_W = 8
);
    logic             in_valid;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic [1:0]       in_op;
    logic [3:0]       in_result;
    logic             in_carry;
    logic             in_zero;
    logic             in_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [SEQ_W+17:0] out_data;

    modport master (
        output in_valid, in_a, in_b, in_op, in_result, in_carry, in_zero, in_overflow,
        output out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_result, in_carry, in_zero, in_overflow,
        input  out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/alu_result_monitor.sv
// Captures ALU writeback records, recomputes the golden result, tags mismatches and
// queues records in a show-ahead FIFO with drop and mismatch counters.
module alu_result_monitor #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SEQ_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_result_monitor_if.slave      bus,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         mismatch_cnt,
    output logic                     mismatch_seen
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned REC_W = SEQ_W + 18;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [SEQ_W-1:0] seq_q;

    // Stage 1: raw capture of the ALU outputs
    logic             s1_valid_q;
    logic [SEQ_W-1:0] s1_seq_q;
    logic [1:0]       s1_op_q;
    logic [3:0]       s1_a_q;
    logic [3:0]       s1_b_q;
    logic [3:0]       s1_res_q;
    logic             s1_carry_q;
    logic             s1_zero_q;
    logic             s1_ovf_q;

    // Stage 2: checked record awaiting FIFO push
    logic             s2_valid_q;
    logic [REC_W-1:0] s2_rec_q;

    logic [4:0] sum;
    logic [4:0] diff;
    logic [3:0] gold_res;
    logic       gold_carry;
    logic       gold_zero;
    logic       gold_ovf;
    logic       mismatch;

    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok;
    logic             pop;
    logic             drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_seq_q   <= '0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_res_q   <= '0;
            s1_carry_q <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                seq_q      <= seq_q + 1'b1;
                s1_seq_q   <= seq_q;
                s1_op_q    <= bus.in_op;
                s1_a_q     <= bus.in_a;
                s1_b_q     <= bus.in_b;
                s1_res_q   <= bus.in_result;
                s1_carry_q <= bus.in_carry;
                s1_zero_q  <= bus.in_zero;
                s1_ovf_q   <= bus.in_overflow;
            end
        end
    end

    always_comb begin
        sum        = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        diff       = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        gold_res   = '0;
        gold_carry = 1'b0;
        gold_ovf   = 1'b0;
        unique case (s1_op_q)
            2'b00: begin
                gold_res   = sum[3:0];
                gold_carry = sum[4];
                gold_ovf   = (s1_a_q[3] == s1_b_q[3]) && (s1_a_q[3] != sum[3]);
            end
            2'b01: begin
                gold_res   = diff[3:0];
                gold_carry = diff[4];
                gold_ovf   = (s1_a_q[3] != s1_b_q[3]) && (s1_a_q[3] != diff[3]);
            end
            2'b10: gold_res = s1_a_q & s1_b_q;
            2'b11: gold_res = s1_a_q | s1_b_q;
        endcase
        gold_zero = (gold_res == 4'h0);
        mismatch  = (gold_res != s1_res_q) || (gold_carry != s1_carry_q) ||
                    (gold_zero != s1_zero_q) || (gold_ovf != s1_ovf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_rec_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_rec_q <= {s1_seq_q, s1_op_q, s1_a_q, s1_b_q, s1_res_q,
                             s1_carry_q, s1_zero_q, s1_ovf_q, mismatch};
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign pop     = (count_q != '0) && bus.out_ready;
    assign push_ok = s2_valid_q && ((count_q != FULL_CNT) || pop);
    assign drop    = s2_valid_q && !push_ok;

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr_q] <= s2_rec_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop) count_q <= count_q - 1'b1;
        end
    end

    // Clear beats a same-cycle increment; counters saturate at all-ones
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            drop_cnt      <= '0;
            mismatch_cnt  <= '0;
            mismatch_seen <= 1'b0;
        end else begin
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
            if (s1_valid_q && mismatch) begin
                mismatch_seen <= 1'b1;
                if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
            end
        end
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem[rd_ptr_q];
    assign fifo_count    = count_q;
endmodule

// File: tb/tb_alu_result_monitor.sv
// Directed bench for alu_result_monitor: golden check, latency, FIFO full/drop,
// full-with-pop throughput, clear priority and reset flush.
module tb_alu_result_monitor;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned SEQ_W = 8;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        logic       c;
        logic       z;
        logic       v;
        logic       m;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [4:0]       fifo_count;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             mismatch_seen;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs [9];

    alu_result_monitor_if #(.SEQ_W(SEQ_W)) bus ();

    alu_result_monitor #(
        .DEPTH(DEPTH),
        .SEQ_W(SEQ_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .clear        (clear),
        .fifo_count   (fifo_count),
        .drop_cnt     (drop_cnt),
        .mismatch_cnt (mismatch_cnt),
        .mismatch_seen(mismatch_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [25:0] rec(input logic [7:0] seq, input vec_t v);
        return {seq, v.op, v.a, v.b, v.r, v.c, v.z, v.v, v.m};
    endfunction

    function automatic vec_t mkadd(input int i);
        vec_t v;
        v.op = 2'b00;
        v.a  = 4'(i);
        v.b  = 4'h0;
        v.r  = 4'(i);
        v.c  = 1'b0;
        v.z  = (4'(i) == 4'h0);
        v.v  = 1'b0;
        v.m  = 1'b0;
        return v;
    endfunction

    task automatic strobe(input vec_t v);
        bus.in_op       = v.op;
        bus.in_a        = v.a;
        bus.in_b        = v.b;
        bus.in_result   = v.r;
        bus.in_carry    = v.c;
        bus.in_zero     = v.z;
        bus.in_overflow = v.v;
        bus.in_valid    = 1'b1;
        tick();
        bus.in_valid    = 1'b0;
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // op, a, b, result, c, z, v, expected mismatch
        vecs[0] = {2'b00, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = {2'b01, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = {2'b01, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = {2'b00, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = {2'b01, 4'h0, 4'h1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = {2'b10, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = {2'b11, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = {2'b10, 4'h5, 4'hA, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = {2'b11, 4'h3, 4'h4, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_op = '0;
        bus.in_result = '0;
        bus.in_carry = 1'b0;
        bus.in_zero = 1'b0;
        bus.in_overflow = 1'b0;
        bus.out_ready = 1'b0;
        do_reset();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_mm_cnt", 64'(mismatch_cnt), 64'd0);
        check("rst_mm_seen", 64'(mismatch_seen), 64'd0);

        // Latency of a single record
        strobe(vecs[0]);
        check("lat_t0", 64'(bus.out_valid), 64'd0);
        tick();
        check("lat_t1", 64'(bus.out_valid), 64'd0);
        tick();
        check("lat_t2", 64'(bus.out_valid), 64'd1);
        check("rec0", 64'(bus.out_data), 64'(rec(8'd0, vecs[0])));
        pop_one();
        check("rec0_popped", 64'(fifo_count), 64'd0);

        // Back-to-back golden-check vectors
        for (int i = 1; i < 9; i++) strobe(vecs[i]);
        tick();
        tick();
        check("vec_count", 64'(fifo_count), 64'd8);
        for (int i = 1; i < 9; i++) begin
            check($sformatf("vec%0d", i), 64'(bus.out_data), 64'(rec(8'(i), vecs[i])));
            pop_one();
        end
        check("vec_mm_cnt", 64'(mismatch_cnt), 64'd3);
        check("vec_mm_seen", 64'(mismatch_seen), 64'd1);

        // Overfill with out_ready low
        do_reset();
        for (int i = 0; i < 20; i++) strobe(mkadd(i));
        tick();
        tick();
        check("full_count", 64'(fifo_count), 64'd16);
        check("full_drop", 64'(drop_cnt), 64'd4);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_seq%0d", i), 64'(bus.out_data[25:18]), 64'(i));
            pop_one();
        end
        check("drain_empty", 64'(bus.out_valid), 64'd0);

        // Full FIFO with concurrent pop: no drops, seq contiguous (base seq 20)
        for (int k = 0; k < 30; k++) begin
            strobe(mkadd(k));
            if (k >= 17) begin
                check($sformatf("thru_count%0d", k), 64'(fifo_count), 64'd16);
                check($sformatf("thru_head%0d", k), 64'(bus.out_data[25:18]), 64'(20 + k - 17));
            end
            if (k == 17) bus.out_ready = 1'b1;
        end
        tick();
        tick();
        bus.out_ready = 1'b0;
        check("thru_drop", 64'(drop_cnt), 64'd4);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("thru_drain%0d", i), 64'(bus.out_data[25:18]), 64'(34 + i));
            pop_one();
        end

        // Clear in the check cycle beats the increment
        strobe(vecs[8]);
        tick();
        check("clr_pre_mm", 64'(mismatch_cnt), 64'd1);
        strobe(vecs[7]);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_mm_cnt", 64'(mismatch_cnt), 64'd0);
        check("clr_mm_seen", 64'(mismatch_seen), 64'd0);
        check("clr_drop", 64'(drop_cnt), 64'd0);
        tick();
        check("clr_count", 64'(fifo_count), 64'd2);
        pop_one();
        check("clr_rec", 64'(bus.out_data), 64'(rec(8'd51, vecs[7])));
        pop_one();

        // Reset with 5 queued and 1 in flight
        for (int i = 0; i < 6; i++) strobe((i == 2) ? vecs[2] : mkadd(i));
        tick();
        check("pre_rst_count", 64'(fifo_count), 64'd5);
        check("pre_rst_mm", 64'(mismatch_cnt), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_valid", 64'(bus.out_valid), 64'd0);
        check("post_rst_count", 64'(fifo_count), 64'd0);
        check("post_rst_mm", 64'(mismatch_cnt), 64'd0);
        tick();
        tick();
        check("post_rst_flush", 64'(fifo_count), 64'd0);
        strobe(vecs[1]);
        tick();
        tick();
        check("post_rst_rec", 64'(bus.out_data), 64'(rec(8'd0, vecs[1])));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
